addsub_exec_stage: RTL and testbench
====================================

# addsub_exec_stage

Execute stage wrapped around the 16-bit two's-complement adder/subtractor (Add16_TwosComp). It accepts operation requests from decode over a valid/ready handshake and derives the adder's Op/Cin from the opcode and the architectural carry flag. It registers the result, destination tag and write-enable toward writeback, and maintains the N/Z/C/V flags register used for multi-word ADC/SBC chaining.

## Interface
Parameters:
- RD_W, default 3: width of the destination-register tag (8 GPRs).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid from decode
- in_ready  out  1  stage can accept a request this cycle
- in_op  in  3  opcode (see Operation)
- in_a  in  16  operand A
- in_b  in  16  operand B
- in_rd  in  RD_W  destination tag
- out_valid  out  1  registered result valid
- out_ready  in  1  writeback accepts result
- out_result  out  16  registered result
- out_rd  out  RD_W  registered destination tag
- out_we  out  1  1 = writeback must write out_rd
- out_err  out  1  1 = illegal opcode was accepted
- flags  out  4  {N,Z,C,V}, architectural flags register

## Operation
- Accept when in_valid && in_ready.
- Opcodes, with ci = current flags C:
  - 000 ADD: A+B, Op=0, Cin=0.
  - 001 ADC: A+B+ci, Op=0, Cin=ci.
  - 010 SUB: A-B, Op=1, Cin=0.
  - 011 SBC: A-B-ci, Op=1, Cin=ci.
  - 100 CMP: A-B; updates flags; out_we=0.
  - 101 INC: A+1, B forced to 0x0001.
  - 110 DEC: A-1, B forced to 0x0001, Op=1.
  - 111 illegal: out_we=0, out_err=1, out_result=0x0000, flags unchanged.
- Result width: out_result is the low 16 bits of the adder S; all arithmetic wraps modulo 2^16.
- Flags are computed from the result R as follows, on every legal op:
  - Z = (R == 0).
  - N = R[15].
  - C for add-type ops (000, 001, 101) = bit 16 of the 17-bit sum A+B+cin.
  - C for sub-type ops (010, 011, 100, 110) = borrow = 1 when unsigned A < B + bin.
  - V for add-type ops = (A[15] == B[15]) && (R[15] != A[15]).
  - V for sub-type ops = (A[15] != B[15]) && (R[15] != A[15]).
- C is computed in-stage from 17-bit arithmetic. It does not rely on the adder's Cout polarity.
- Pending-result rules:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - On accept, out_* and flags load at the same edge.
  - While out_valid && !out_ready, all out_* and flags hold stable.

## Timing
- Latency: 1 cycle. A request accepted at edge k has its out_valid, result and flags visible after edge k.
- Throughput: 1 op/cycle while out_ready=1.
- Back-to-back chaining: ADC/SBC accepted at edge k+1 uses the C written at edge k.
- out_valid clears at the edge where out_valid && out_ready && !(in_valid && in_ready).
- Simultaneous drain and accept: out_valid stays 1 and the new result replaces the old one.
- Reset (async assert, sync-to-clk release): out_valid=0, out_result=0x0000, out_rd=0, out_we=0, out_err=0, flags=4'b0000. in_ready=1 after reset.
- Reset mid-operation: the pending result is discarded and not presented after release.
- Inputs are sampled only on accept. Changes to in_* while !in_ready have no effect.

## Test plan
- ADD 0x7FFF+0x0001 -> next cycle: out_result=0x8000, out_we=1, flags N=1 Z=0 C=0 V=1.
- ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000 back-to-back:
  - first op -> 0x0000, Z=1 C=1.
  - second op -> 0x0001, C=0 Z=0.
- SUB 0x0001-0x0002 -> 0xFFFF, N=1 C=1 V=0. Then SBC 0x0005-0x0001 -> 0x0003, C=0.
- CMP 0x1234,0x1234 -> out_valid=1, out_we=0, Z=1 C=0. Opcode 111 -> out_err=1, out_we=0, flags unchanged.
- Backpressure: issue ADD 0x0002+0x0003 with out_ready=0.
  - out_result=0x0005 holds and in_ready=0 for 3 cycles.
  - A queued INC 0x0009 is not accepted.
  - Raise out_ready: 0x0005 drains, INC is accepted, 0x000A appears the next cycle.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> all outputs 0 immediately. After release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/addsub_exec_stage.sv
// Execute stage around a 16-bit two's-complement adder/subtractor: decodes the opcode into
// Op/Cin and registers the result, destination tag and N/Z/C/V flags behind a valid/ready handshake.
module addsub_exec_stage #(
    parameter int unsigned RD_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic            out_err,
    output logic [3:0]      flags
);

    logic            out_valid_q;
    logic [15:0]     out_result_q, out_result_d;
    logic [RD_W-1:0] out_rd_q;
    logic            out_we_q, out_we_d;
    logic            out_err_q, out_err_d;
    logic [3:0]      flags_q, flags_d;

    logic        accept;
    logic        op_sub;
    logic        cin;
    logic        illegal;
    logic        is_cmp;
    logic [15:0] b_opd;
    logic [16:0] sum17;
    logic [15:0] res;
    logic        flag_n, flag_z, flag_c, flag_v;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Opcode decode into adder controls; carry-in comes from the architectural C flag.
    always_comb begin
        op_sub  = 1'b0;
        cin     = 1'b0;
        illegal = 1'b0;
        is_cmp  = 1'b0;
        b_opd   = in_b;
        unique case (in_op)
            3'b000: ;
            3'b001: cin = flags_q[1];
            3'b010: op_sub = 1'b1;
            3'b011: begin
                op_sub = 1'b1;
                cin    = flags_q[1];
            end
            3'b100: begin
                op_sub = 1'b1;
                is_cmp = 1'b1;
            end
            3'b101: b_opd = 16'h0001;
            3'b110: begin
                op_sub = 1'b1;
                b_opd  = 16'h0001;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Subtraction uses A + ~B + !borrow_in so one adder serves both directions.
    assign sum17 = {1'b0, in_a} + {1'b0, (op_sub ? ~b_opd : b_opd)}
                 + {16'h0000, (op_sub ? !cin : cin)};
    assign res   = sum17[15:0];

    always_comb begin
        flag_n = res[15];
        flag_z = (res == 16'h0000);
        if (op_sub) begin
            flag_c = ({1'b0, in_a} < ({1'b0, b_opd} + {16'h0000, cin}));
            flag_v = (in_a[15] != b_opd[15]) && (res[15] != in_a[15]);
        end else begin
            flag_c = sum17[16];
            flag_v = (in_a[15] == b_opd[15]) && (res[15] != in_a[15]);
        end
    end

    always_comb begin
        out_result_d = res;
        out_we_d     = !is_cmp;
        out_err_d    = 1'b0;
        flags_d      = {flag_n, flag_z, flag_c, flag_v};
        if (illegal) begin
            out_result_d = 16'h0000;
            out_we_d     = 1'b0;
            out_err_d    = 1'b1;
            flags_d      = flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 16'h0000;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_err_q    <= 1'b0;
            flags_q      <= 4'b0000;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_result_q <= out_result_d;
            out_rd_q     <= in_rd;
            out_we_q     <= out_we_d;
            out_err_q    <= out_err_d;
            flags_q      <= flags_d;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_we     = out_we_q;
    assign out_err    = out_err_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_addsub_exec_stage.sv
// Scoreboarded bench for addsub_exec_stage: an arithmetic reference model predicts each
// accepted operation; a monitor compares whenever a result is handed to writeback.
module tb_addsub_exec_stage;

    localparam int RD_W = 3;

    typedef struct packed {
        logic [15:0]     result;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            err;
        logic [3:0]      flags;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = '0;
    logic [15:0]     in_a = '0;
    logic [15:0]     in_b = '0;
    logic [RD_W-1:0] in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [15:0]     out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_we;
    logic            out_err;
    logic [3:0]      flags;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    logic [3:0] ref_flags = 4'b0000;

    addsub_exec_stage #(.RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_err(out_err), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input logic [2:0] op, input int a, input int b,
                                   input logic [RD_W-1:0] rd, input logic [3:0] fl);
        exp_t e;
        int   ci, bb, cc, s, r;
        bit   sub;
        ci  = int'(fl[1]);
        bb  = b;
        cc  = 0;
        sub = 0;
        e.rd = rd;
        e.we = 1'b1;
        e.err = 1'b0;
        case (op)
            3'd0: ;
            3'd1: cc = ci;
            3'd2: sub = 1;
            3'd3: begin sub = 1; cc = ci; end
            3'd4: begin sub = 1; e.we = 1'b0; end
            3'd5: bb = 1;
            3'd6: begin sub = 1; bb = 1; end
            default: begin
                e.result = 16'h0000;
                e.we     = 1'b0;
                e.err    = 1'b1;
                e.flags  = fl;
                return e;
            end
        endcase
        s = sub ? (a - bb - cc) : (a + bb + cc);
        r = s & 32'hFFFF;
        e.result   = r[15:0];
        e.flags[3] = r[15];
        e.flags[2] = (r == 0);
        e.flags[1] = sub ? (s < 0) : (s > 65535);
        if (sub) e.flags[0] = (a[15] != bb[15]) && (r[15] != a[15]);
        else     e.flags[0] = (a[15] == bb[15]) && (r[15] != a[15]);
        return e;
    endfunction

    // Drive one cycle of stimulus; returns whether the DUT will accept it at the next edge.
    task automatic issue(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [RD_W-1:0] rd, input logic ordy,
                         output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_rd     = rd;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e = model(op, int'(a), int'(b), rd, ref_flags);
            ref_flags = e.flags;
            sb_q.push_back(e);
        end
    endtask

    task automatic dir_op(input string name, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic [3:0] exp_fl, input logic exp_we, input logic exp_err);
        logic acc;
        issue(1'b1, op, a, b, 3'd5, 1'b1, acc);
        check({name, " accepted"}, 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " result"}, 32'(out_result), 32'(exp_res));
        check({name, " flags"}, 32'(flags), 32'(exp_fl));
        check({name, " we"}, 32'(out_we), 32'(exp_we));
        check({name, " err"}, 32'(out_err), 32'(exp_err));
    endtask

    // Monitor: a result counts as delivered when out_valid && out_ready before an edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got result 0x%0h, expected none",
                             out_result);
                end else begin
                    e = sb_q.pop_front();
                    check("sb result", 32'(out_result), 32'(e.result));
                    check("sb rd", 32'(out_rd), 32'(e.rd));
                    check("sb we", 32'(out_we), 32'(e.we));
                    check("sb err", 32'(out_err), 32'(e.err));
                    check("sb flags", 32'(flags), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        logic acc;
        int   guard;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_result", 32'(out_result), 32'd0);
        check("rst flags", 32'(flags), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        dir_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1, 1'b0);
        dir_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b1, 1'b0);
        dir_op("adc_chain", 3'd1, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b1, 1'b0);
        dir_op("sub_borrow", 3'd2, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1'b1, 1'b0);
        dir_op("sbc_chain", 3'd3, 16'h0005, 16'h0001, 16'h0003, 4'b0000, 1'b1, 1'b0);
        dir_op("cmp_eq", 3'd4, 16'h1234, 16'h1234, 16'h0000, 4'b0100, 1'b0, 1'b0);
        dir_op("illegal", 3'd7, 16'hAAAA, 16'h5555, 16'h0000, 4'b0100, 1'b0, 1'b1);
        dir_op("dec_zero", 3'd6, 16'h0000, 16'h9999, 16'hFFFF, 4'b1010, 1'b1, 1'b0);

        // Backpressure: result held, queued INC refused until out_ready rises.
        issue(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        issue(1'b1, 3'd0, 16'h0002, 16'h0003, 3'd2, 1'b0, acc);
        check("bp add accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 3'd5, 16'h0009, 16'h7777, 3'd3, 1'b0, acc);
            check("bp inc refused", 32'(acc), 32'd0);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp hold result", 32'(out_result), 32'h5);
            check("bp hold flags", 32'(flags), 32'h0);
        end
        issue(1'b1, 3'd5, 16'h0009, 16'h7777, 3'd3, 1'b1, acc);
        check("bp inc accepted", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        check("bp inc result", 32'(out_result), 32'h000A);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), acc);
        end

        // Drain before the reset test.
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            issue(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            guard++;
        end
        check("drain timeout", 32'(sb_q.size()), 32'd0);

        // Reset while a result is pending under backpressure.
        issue(1'b1, 3'd0, 16'h1111, 16'h2222, 3'd7, 1'b0, acc);
        @(posedge clk);
        #3;
        check("pre-rst out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 32'(out_valid), 32'd0);
        check("mid-rst result", 32'(out_result), 32'd0);
        check("mid-rst rd", 32'(out_rd), 32'd0);
        check("mid-rst flags", 32'(flags), 32'd0);
        sb_q.delete();
        ref_flags = 4'b0000;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            check("post-rst out_valid", 32'(out_valid), 32'd0);
            check("post-rst in_ready", 32'(in_ready), 32'd1);
        end
        dir_op("post-rst adc", 3'd1, 16'h0010, 16'h0001, 16'h0011, 4'b0000, 1'b1, 1'b0);
        issue(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        issue(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        check("final queue empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
